// File: rtl/fetch_pkg.sv
// Shared definitions for the fetch-buffer controller: FSM encodings,
// flush-cause bit positions and default geometry.
package fetch_pkg;

    localparam int DEF_NUM_ENTRIES = 4;
    localparam int DEF_MAX_REL     = 2;

    typedef enum logic [1:0] {
        FETCH_IDLE = 2'b00,
        FETCH_FILL = 2'b01,
        FETCH_FULL = 2'b10
    } fetch_state_e;

    // Bit positions inside the internal flush-cause vector.
    localparam int FLUSH_INT    = 0;
    localparam int FLUSH_IC_EXP = 1;
    localparam int FLUSH_DC_EXP = 2;
    localparam int FLUSH_BR     = 3;
    localparam int FLUSH_W      = 4;

endpackage

// File: rtl/fetch_buf_ctrl_if.sv
// Bundle of I-cache, decoder and status signals around the fetch-buffer controller.
// The interrupt flush input is named int_i because "int" is a reserved word.
interface fetch_buf_ctrl_if
    import fetch_pkg::*;
#(
    parameter int NUM_ENTRIES = DEF_NUM_ENTRIES,
    parameter int MAX_REL     = DEF_MAX_REL
);
    localparam int PTR_W = $clog2(NUM_ENTRIES);
    localparam int REL_W = $clog2(MAX_REL + 1);

    // Handshake: ic_req is a request (valid) toward the I-cache and ic_hit is its
    // per-cycle acceptance; a chunk is written only in a cycle where both are 1.
    logic                   ic_hit;
    logic                   int_i;
    logic                   ic_exp;
    logic                   dc_exp;
    logic                   de_br_stall;
    logic                   r_V_de;
    logic [REL_W-1:0]       de_rel;
    logic                   ic_req;
    logic [NUM_ENTRIES-1:0] f_ld_buf;
    logic                   f_address_sel;
    logic [PTR_W-1:0]       f_rd_ptr;
    logic [NUM_ENTRIES-1:0] f_valid;
    logic [PTR_W:0]         f_count;
    logic [1:0]             f_curr_st;
    logic                   f_rel_err;
    logic [31:0]            f_miss_cyc;
    logic [31:0]            f_full_cyc;

    modport slave (
        input  ic_hit, int_i, ic_exp, dc_exp, de_br_stall, r_V_de, de_rel,
        output ic_req, f_ld_buf, f_address_sel, f_rd_ptr, f_valid, f_count,
               f_curr_st, f_rel_err, f_miss_cyc, f_full_cyc
    );

    modport master (
        output ic_hit, int_i, ic_exp, dc_exp, de_br_stall, r_V_de, de_rel,
        input  ic_req, f_ld_buf, f_address_sel, f_rd_ptr, f_valid, f_count,
               f_curr_st, f_rel_err, f_miss_cyc, f_full_cyc
    );

endinterface

// File: rtl/fetch_ring_ptr.sv
// Wrap-around slot pointer advanced by a variable step each cycle; clr_i returns it to 0.
module fetch_ring_ptr #(
    parameter int PTR_W = 2,
    parameter int INC_W = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr_i,
    input  logic [INC_W-1:0] inc_i,
    output logic [PTR_W-1:0] ptr_o
);

    logic [PTR_W-1:0] ptr_q, ptr_d;

    // Power-of-two depth: truncation of the sum is the modulo wrap.
    assign ptr_d = clr_i ? '0 : ptr_q + PTR_W'(inc_i);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) ptr_q <= '0;
        else        ptr_q <= ptr_d;
    end

    assign ptr_o = ptr_q;

endmodule

// File: rtl/fetch_buf_ctrl.sv
// N-entry circular fetch-buffer controller between I-cache and decoder.
// Optional stall counters enabled by defining FETCH_PERF_CNT_EN.
module fetch_buf_ctrl
    import fetch_pkg::*;
#(
    parameter int NUM_ENTRIES = DEF_NUM_ENTRIES,
    parameter int MAX_REL     = DEF_MAX_REL,
    localparam int PTR_W      = $clog2(NUM_ENTRIES),
    localparam int REL_W      = $clog2(MAX_REL + 1)
) (
    input  logic              clk,
    input  logic              rst_n,
    fetch_buf_ctrl_if.slave   fb
);

    localparam logic [PTR_W:0] FULL_CNT = (PTR_W+1)'(NUM_ENTRIES);

    logic [FLUSH_W-1:0]     flush_vec;
    logic                   flush, load, rel_err_hit;
    logic [REL_W-1:0]       rel;
    logic [PTR_W-1:0]       wr_ptr, rd_ptr;
    logic [PTR_W:0]         count_q, count_d;
    logic [NUM_ENTRIES-1:0] valid_q, valid_d;
    fetch_state_e           state_q, state_d;
    logic                   addr_sel_q, rel_err_q;

    assign flush_vec[FLUSH_INT]    = fb.int_i;
    assign flush_vec[FLUSH_IC_EXP] = fb.ic_exp;
    assign flush_vec[FLUSH_DC_EXP] = fb.dc_exp;
    assign flush_vec[FLUSH_BR]     = fb.de_br_stall;
    assign flush = |flush_vec;

    // Space is judged on the registered count only, keeping release off the request path.
    assign fb.ic_req   = ~flush & (count_q < FULL_CNT);
    assign load        = fb.ic_req & fb.ic_hit;
    assign fb.f_ld_buf = load ? (NUM_ENTRIES'(1) << wr_ptr) : '0;

    always_comb begin
        rel         = '0;
        rel_err_hit = 1'b0;
        if (fb.r_V_de) begin
            if (int'(fb.de_rel) > int'(count_q)) begin
                rel         = REL_W'(count_q);
                rel_err_hit = 1'b1;
            end else begin
                rel = fb.de_rel;
            end
        end
    end

    always_comb begin
        count_d = count_q + (PTR_W+1)'(load) - (PTR_W+1)'(rel);
        valid_d = valid_q;
        if (load) valid_d[wr_ptr] = 1'b1;
        for (int i = 0; i < MAX_REL; i++) begin
            if (i < int'(rel)) valid_d[rd_ptr + PTR_W'(i)] = 1'b0;
        end
        // Once anything has been fetched since the last flush, an empty buffer stays in FILL.
        if (count_d == FULL_CNT)                  state_d = FETCH_FULL;
        else if (state_q != FETCH_IDLE || load)   state_d = FETCH_FILL;
        else                                      state_d = FETCH_IDLE;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= FETCH_IDLE;
            count_q    <= '0;
            valid_q    <= '0;
            addr_sel_q <= 1'b0;
            rel_err_q  <= 1'b0;
        end else if (flush) begin
            state_q    <= FETCH_IDLE;
            count_q    <= '0;
            valid_q    <= '0;
            addr_sel_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            count_q    <= count_d;
            valid_q    <= valid_d;
            addr_sel_q <= addr_sel_q | load;
            rel_err_q  <= rel_err_q | rel_err_hit;
        end
    end

    fetch_ring_ptr #(.PTR_W(PTR_W), .INC_W(1)) u_wr_ptr (
        .clk(clk), .rst_n(rst_n), .clr_i(flush), .inc_i(load), .ptr_o(wr_ptr)
    );

    fetch_ring_ptr #(.PTR_W(PTR_W), .INC_W(REL_W)) u_rd_ptr (
        .clk(clk), .rst_n(rst_n), .clr_i(flush), .inc_i(rel), .ptr_o(rd_ptr)
    );

`ifdef FETCH_PERF_CNT_EN
    logic [31:0] miss_q, full_q;

    // Saturating counters; flush leaves them alone, only reset clears them.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            miss_q <= '0;
            full_q <= '0;
        end else begin
            if (fb.ic_req && !fb.ic_hit && miss_q != '1)        miss_q <= miss_q + 32'd1;
            if (state_q == FETCH_FULL && rel == '0 && full_q != '1) full_q <= full_q + 32'd1;
        end
    end

    assign fb.f_miss_cyc = miss_q;
    assign fb.f_full_cyc = full_q;
`else
    assign fb.f_miss_cyc = '0;
    assign fb.f_full_cyc = '0;
`endif

    assign fb.f_address_sel = addr_sel_q;
    assign fb.f_rd_ptr      = rd_ptr;
    assign fb.f_valid       = valid_q;
    assign fb.f_count       = count_q;
    assign fb.f_curr_st     = state_q;
    assign fb.f_rel_err     = rel_err_q;

endmodule
